// File: rtl/instruction_encoder_if.sv
// Field/handshake bundle for instruction_encoder: decoded fields in, packed words out.
// The slave modport is the encoder's view and the master modport is the loader's view.
interface instruction_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [6:0]    op;
  logic [12:0]   off;
  logic [3:0]    c;
  logic [2:0]    t;
  logic [2:0]    f;
  logic [2:0]    pr;
  logic [3:0]    sa;
  logic [4:0]    pswb;
  logic [2:0]    dst;
  logic [2:0]    srccon;
  logic          wb;
  logic          rc;
  logic [7:0]    imbyte;
  logic          prpo;
  logic          dec;
  logic          inc;
  logic          clear;
  logic [15:0]   instr;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   addr;
  logic [CW-1:0] count;
  logic          flt;
  logic [6:0]    fltop;

  modport slave (
    input  in_valid, op, off, c, t, f, pr, sa, pswb, dst, srccon, wb, rc,
           imbyte, prpo, dec, inc, clear, out_ready,
    output in_ready, instr, out_valid, addr, count, flt, fltop
  );

  modport master (
    output in_valid, op, off, c, t, f, pr, sa, pswb, dst, srccon, wb, rc,
           imbyte, prpo, dec, inc, clear, out_ready,
    input  in_ready, instr, out_valid, addr, count, flt, fltop
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded XM-23 fields into 16-bit words, queues them in a FIFO and drains them with byte addresses.
// Optional macro ENC_RANGE_CHECK_EN: faults BRA/LDR/STR offsets that are not sign extensions of their field.
module instruction_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input logic                  i_clk,
  input logic                  i_rst,
  instruction_encoder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_addr;
  logic          r_flt;
  logic [6:0]    r_fltOp;

  logic [15:0] w_word;
  logic        w_opOk;
  logic [3:0]  w_aluIdx;
  logic [1:0]  w_movIdx;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_fault;

  // Low-bit arithmetic yields the ALU (ADD..BIS) and MOVL..MOVH sub-opcodes directly.
  assign w_aluIdx = bus.op[3:0] - 4'd7;
  assign w_movIdx = bus.op[1:0] - 2'd2;

  always_comb begin
    w_word = 16'h0000;
    w_opOk = 1'b1;
    case (bus.op) inside
      7'd0: w_word = {3'b000, bus.off};
      7'd1: begin
        w_word = {6'b001000, bus.off[9:0]};
`ifdef ENC_RANGE_CHECK_EN
        w_opOk = (bus.off[12:10] == {3{bus.off[9]}});
`endif
      end
      7'd2:  w_word = {6'b001001, bus.c, bus.t, bus.f};
      7'd3:  w_word = {13'h0500, bus.pr};
      7'd4:  w_word = {12'h281, bus.sa};
      7'd5:  w_word = {11'h141, bus.pswb};
      7'd6:  w_word = {11'h142, bus.pswb};
      [7'd7:7'd17]:
        w_word = {4'b0100, w_aluIdx, bus.rc, bus.wb, bus.srccon, bus.dst};
      7'd18: w_word = {8'h4C, 1'b0, bus.wb, bus.srccon, bus.dst};
      7'd19: w_word = {8'h4C, 1'b1, 1'b0, bus.srccon, bus.dst};
      7'd20: w_word = {8'h4D, 1'b0, bus.wb, 3'b000, bus.dst};
      7'd21: w_word = {8'h4D, 1'b1, bus.wb, 3'b000, bus.dst};
      7'd22: w_word = {13'h09C0, bus.dst};
      7'd23: w_word = {13'h09C1, bus.dst};
      7'd24, 7'd25:
        w_word = {5'b01011, bus.op[0], bus.prpo, bus.dec, bus.inc, bus.wb,
                  bus.srccon, bus.dst};
      [7'd26:7'd29]:
        w_word = {3'b011, w_movIdx, bus.imbyte, bus.dst};
      7'd30, 7'd31: begin
        w_word = {1'b1, bus.op[0], bus.off[6:0], bus.wb, bus.srccon, bus.dst};
`ifdef ENC_RANGE_CHECK_EN
        w_opOk = (bus.off[12:7] == {6{bus.off[6]}});
`endif
      end
      7'd32:   w_word = 16'h5000;
      default: w_opOk = 1'b0;
    endcase
  end

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = bus.in_valid & ~w_full;
  assign w_push   = w_accept & w_opOk;
  assign w_fault  = w_accept & ~w_opOk;
  assign w_pop    = ~w_empty & bus.out_ready;

  // Circular buffer; the address counter only moves when a word leaves.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 16'h0000;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= w_word;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
        r_addr  <= r_addr + 16'd2;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // A new fault wins over a simultaneous clear so it is never lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flt   <= 1'b0;
      r_fltOp <= 7'd0;
    end else if (w_fault) begin
      r_flt   <= 1'b1;
      r_fltOp <= bus.op;
    end else if (bus.clear) begin
      r_flt   <= 1'b0;
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.instr     = r_mem[r_rdPtr];
  assign bus.addr      = r_addr;
  assign bus.count     = r_count;
  assign bus.flt       = r_flt;
  assign bus.fltop     = r_fltOp;
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Inverse of the instruction decoder. Accepts decoded instruction fields (OP code plus operand fields, same numbering and widths the decoder emits) and packs them into 16-bit XM-23 instruction words. Encoded words are buffered in a small FIFO and drained with a byte address, for a loader or test harness writing instruction memory. OP codes outside the defined set raise a sticky fault.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >=2)
BASE_ADDR, 16'h0000, address presented with the first word after reset

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
In_valid  in  1  field set valid
In_ready  out  1  encoder can accept (FIFO not full)
OP  in  7  opcode number 0..32 (decoder numbering)
OFF  in  13  BL offset [12:0]; BRA [9:0]; LDR/STR [6:0]
C  in  4  CEX condition
T  in  3  CEX true count
F  in  3  CEX false count
PR  in  3  SETPRI priority
SA  in  4  SVC number
PSWb  in  5  SETCC/CLRCC bits
DST  in  3  destination reg
SRCCON  in  3  source reg/constant
WB  in  1  word/byte
RC  in  1  reg/const
ImByte  in  8  MOVx immediate
PRPO, DEC, INC  in  1 each  LD/ST addressing bits
Clear  in  1  clears FLT
Instr  out  16  FIFO head word
Out_valid  out  1  FIFO not empty
Out_ready  in  1  consumer takes head
Addr  out  16  byte address of head word
Count  out  clog2(DEPTH)+1  FIFO occupancy
FLT  out  1  sticky invalid-OP fault
FltOp  out  7  OP that caused latest fault

Behaviour:
- Reset (async): FIFO empty, Count=0, Out_valid=0, In_ready=1, Instr=0, Addr=BASE_ADDR, FLT=0, FltOp=0.
- Push when In_valid&In_ready at posedge. Word visible at Instr one cycle later if FIFO was empty (registered, latency 1).
- Pop when Out_valid&Out_ready. Addr += 2 per pop; 16'hFFFE wraps to 16'h0000.
- Push and pop in one cycle, FIFO neither empty nor full: both happen, Count unchanged. Full: In_ready=0, so no push even if popping that cycle. No bypass path.
- Encoding (unused fields ignored, unused bits 0):
  - OP0 BL: 000|OFF[12:0].
  - OP1 BRA: 0x2000|OFF[9:0].
  - OP2 CEX: 0x2400|C<<6|T<<3|F.
  - OP3 SETPRI: 0x2800|PR.
  - OP4 SVC: 0x2810|SA.
  - OP5 SETCC: 0x2820|PSWb.
  - OP6 CLRCC: 0x2840|PSWb.
  - OP7..17 ADD..BIS: 0x4000|(OP-7)<<8|RC<<7|WB<<6|SRCCON<<3|DST.
  - OP18 MOV: 0x4C00|WB<<6|SRCCON<<3|DST.
  - OP19 SWAP: 0x4C80|SRCCON<<3|DST.
  - OP20 SRA: 0x4D00|WB<<6|DST.
  - OP21 RRC: 0x4D80|WB<<6|DST.
  - OP22 SWPB: 0x4E00|DST.
  - OP23 SXT: 0x4E08|DST.
  - OP24 LD / OP25 ST: 0x5800/0x5C00|PRPO<<9|DEC<<8|INC<<7|WB<<6|SRCCON<<3|DST.
  - OP26..29 MOVL/MOVLZ/MOVLS/MOVH: 0x6000/0x6800/0x7000/0x7800|ImByte<<3|DST.
  - OP30 LDR / OP31 STR: 0x8000/0xC000|OFF[6:0]<<7|WB<<6|SRCCON<<3|DST.
  - OP32 BREAKPOINT: 0x5000.
- OP>32 on accepted input: no push; FLT=1, FltOp=OP next cycle. In_ready unaffected.
- Clear deasserts FLT next cycle. A fault in the same cycle as Clear takes priority: FLT stays 1.
- Reset mid-stream flushes the FIFO and drops any in-flight accept.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined: OFF must be a sign extension of the encoded field. BRA requires OFF[12:10]==3{OFF[9]}; LDR/STR require OFF[12:7]==6{OFF[6]}. On violation, treat as fault: no push, FLT=1, FltOp=OP.
- Undefined: OFF is silently truncated.

Test Plan:
- Reset asserted mid-fill -> Count=0, Out_valid=0, In_ready=1, Addr=0x0000, FLT=0.
- ADD OP=7 RC=0 WB=1 SRCCON=3 DST=2 -> next cycle Out_valid=1, Instr=0x405A, Addr=0x0000.
- MOVL ImByte=0xA5 DST=1 then MOVH same fields -> Instr 0x6529 then 0x7D29, Addr 0x0000 then 0x0002.
- Push 4 words with Out_ready=0 -> Count=4, In_ready=0, 5th not taken. Then Out_ready=1 -> words pop in order, Addr 0,2,4,6, Count returns to 0.
- OP=33 -> FLT=1, FltOp=33, Count unchanged. Clear -> FLT=0. LDR OFF=0x003F, other fields 0 -> Instr=0x9F80.
- ENC_RANGE_CHECK_EN: BRA OFF=0x1200 -> FLT=1, no push. BRA OFF=0x1E00 -> Instr=0x2200.
